// File: rtl/garegga_gfx_arb_pkg.sv
// Shared types and constants for the graphics-bank round-robin arbiter.
package garegga_gfx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 22;

    localparam int REQ_OBJ  = 0;
    localparam int REQ_SCR0 = 1;
    localparam int REQ_SCR1 = 2;
    localparam int REQ_SCR2 = 3;

endpackage

// File: rtl/garegga_gfx_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after rr_ptr,
// wrapping modulo NREQ.
module garegga_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   rr_ptr,
    output logic            any,
    output logic [IW-1:0]   win
);

    // Scan from the far end back toward rr_ptr so the closest hit is kept last.
    always_comb begin
        int          idx;
        logic [IW-1:0] cand;
        any  = 1'b0;
        win  = rr_ptr;
        idx  = 0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IW'(idx);
            if (pending[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

endmodule

// File: rtl/garegga_gfx_arbiter.sv
// Round-robin arbiter sharing one SDRAM bank read port among the GP9001
// graphics ROM requesters; assembles two 16-bit beats into a 32-bit word
// per requester.
// Build option: GARE_GFX_ARB_CACHE_EN keeps a requester's result valid while
// its CS is low, so a re-assert with the same address hits without a fetch.
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | arbitrate among pending requesters
// ST_REQ  | BA_RD high with the latched address, waiting ACK
// ST_DATA | collecting the low beat, committing on BA_RDY
module garegga_gfx_arbiter
    import garegga_gfx_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NREQ-1:0]   REQ_CS,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    output logic [NREQ-1:0]   REQ_OK,
    output logic [NREQ*32-1:0] REQ_DOUT,
    output logic [AW-1:0]     BA_ADDR,
    output logic              BA_RD,
    input  logic              BA_ACK,
    input  logic              BA_DOK,
    input  logic              BA_RDY,
    input  logic [15:0]       DATA_READ
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  win_q, win_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           ba_rd_q, ba_rd_d;
    logic           beat_q, beat_d;
    logic [15:0]    lo_q, lo_d;
    logic [NREQ-1:0] valid_q, valid_d;
    logic [AW-1:0]  last_addr_q [NREQ];
    logic [AW-1:0]  last_addr_d [NREQ];
    logic [31:0]    dout_q [NREQ];
    logic [31:0]    dout_d [NREQ];

    logic [AW-1:0]  req_addr_a [NREQ];
    logic [NREQ-1:0] req_ok;
    logic [NREQ-1:0] pending;
    logic           pick_any;
    logic [IW-1:0]  pick_win;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        assign req_addr_a[gi]          = REQ_ADDR[gi*AW +: AW];
        assign req_ok[gi]              = REQ_CS[gi] & valid_q[gi] &
                                         (req_addr_a[gi] == last_addr_q[gi]);
        assign REQ_DOUT[gi*32 +: 32]   = dout_q[gi];
    end

    assign REQ_OK  = req_ok;
    assign pending = REQ_CS & ~req_ok;
    assign BA_RD   = ba_rd_q;
    assign BA_ADDR = addr_q;

    garegga_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr_q),
        .any     (pick_any),
        .win     (pick_win)
    );

    // Next-state logic for the arbitration FSM and per-requester result slots.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = addr_q;
        ba_rd_d     = ba_rd_q;
        beat_d      = beat_q;
        lo_d        = lo_q;
        valid_d     = valid_q;
        last_addr_d = last_addr_q;
        dout_d      = dout_q;
`ifndef GARE_GFX_ARB_CACHE_EN
        // Without the cache every CS drop forgets the slot.
        valid_d     = valid_q & REQ_CS;
`endif
        unique case (state_q)
            ST_IDLE: begin
                beat_d = 1'b0;
                if (pick_any) begin
                    win_d   = pick_win;
                    addr_d  = req_addr_a[pick_win];
                    ba_rd_d = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (BA_ACK) begin
                    ba_rd_d = 1'b0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (BA_RDY) begin
                    dout_d[win_q]      = {DATA_READ, lo_q};
                    last_addr_d[win_q] = addr_q;
`ifdef GARE_GFX_ARB_CACHE_EN
                    valid_d[win_q]     = 1'b1;
`else
                    // A requester that dropped CS mid-fetch gets the data but no valid.
                    valid_d[win_q]     = REQ_CS[win_q];
`endif
                    rr_ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    state_d  = ST_IDLE;
                end else if (BA_DOK && !beat_q) begin
                    lo_d   = DATA_READ;
                    beat_d = 1'b1;
                end
            end
            default: begin
                ba_rd_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight burst.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            ba_rd_q  <= 1'b0;
            beat_q   <= 1'b0;
            lo_q     <= '0;
            valid_q  <= '0;
            for (int i = 0; i < NREQ; i++) begin
                last_addr_q[i] <= '0;
                dout_q[i]      <= '0;
            end
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            rr_ptr_q    <= rr_ptr_d;
            addr_q      <= addr_d;
            ba_rd_q     <= ba_rd_d;
            beat_q      <= beat_d;
            lo_q        <= lo_d;
            valid_q     <= valid_d;
            last_addr_q <= last_addr_d;
            dout_q      <= dout_d;
        end
    end

endmodule

// File: tb/tb_garegga_gfx_arbiter.sv
// Directed self-checking bench for garegga_gfx_arbiter.
module tb_garegga_gfx_arbiter;
    import garegga_gfx_arb_pkg::*;

    localparam int NREQ = NREQ_DEF;
    localparam int AW   = AW_DEF;

    logic                 CLK = 1'b0;
    logic                 RESET = 1'b1;
    logic [NREQ-1:0]      REQ_CS = '0;
    logic [NREQ*AW-1:0]   REQ_ADDR = '0;
    logic [NREQ-1:0]      REQ_OK;
    logic [NREQ*32-1:0]   REQ_DOUT;
    logic [AW-1:0]        BA_ADDR;
    logic                 BA_RD;
    logic                 BA_ACK = 1'b0;
    logic                 BA_DOK = 1'b0;
    logic                 BA_RDY = 1'b0;
    logic [15:0]          DATA_READ = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    garegga_gfx_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ_CS    (REQ_CS),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_OK    (REQ_OK),
        .REQ_DOUT  (REQ_DOUT),
        .BA_ADDR   (BA_ADDR),
        .BA_RD     (BA_RD),
        .BA_ACK    (BA_ACK),
        .BA_DOK    (BA_DOK),
        .BA_RDY    (BA_RDY),
        .DATA_READ (DATA_READ)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dout_of(input int i);
        return REQ_DOUT[i*32 +: 32];
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        REQ_ADDR[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        REQ_CS = '0; BA_ACK = 1'b0; BA_DOK = 1'b0; BA_RDY = 1'b0; DATA_READ = '0;
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); @(negedge CLK); RESET = 1'b0;
        @(negedge CLK);
    endtask

    // Waits (bounded) at negedges for BA_RD and checks the presented address.
    task automatic wait_rd(input string tag, input logic [AW-1:0] exp_addr);
        int n = 0;
        while (BA_RD !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_rd"}, 64'(BA_RD), 64'(1));
        chk({tag, "_addr"}, 64'(BA_ADDR), 64'(exp_addr));
    endtask

    // Bank model: optional ACK delay (with a spurious DOK/RDY in REQ), then two beats.
    task automatic bank_burst(input string tag, input int ack_dly, input logic [AW-1:0] exp_addr,
                              input logic [15:0] lo, input logic [15:0] hi, input bit spurious);
        wait_rd(tag, exp_addr);
        for (int d = 0; d < ack_dly; d++) begin
            BA_DOK    = spurious && (d == 1);
            BA_RDY    = BA_DOK;
            DATA_READ = BA_DOK ? 16'h5A5A : 16'h0000;
            @(negedge CLK);
            chk({tag, "_hold_rd"}, 64'(BA_RD), 64'(1));
            chk({tag, "_hold_addr"}, 64'(BA_ADDR), 64'(exp_addr));
        end
        BA_DOK = 1'b0; BA_RDY = 1'b0; BA_ACK = 1'b1;
        @(negedge CLK);
        BA_ACK = 1'b0; BA_DOK = 1'b1; DATA_READ = lo;
        @(negedge CLK);
        BA_RDY = 1'b1; DATA_READ = hi;
        @(negedge CLK);
        BA_DOK = 1'b0; BA_RDY = 1'b0; DATA_READ = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int c0;

        // Reset state
        @(negedge CLK); @(negedge CLK);
        chk("rst_ba_rd", 64'(BA_RD), 64'(0));
        chk("rst_ba_addr", 64'(BA_ADDR), 64'(0));
        chk("rst_ok", 64'(REQ_OK), 64'(0));
        chk("rst_dout", 64'(REQ_DOUT[63:0]), 64'(0));
        RESET = 1'b0;
        @(negedge CLK);

        // Single request on SCR0, minimum latency
        set_addr(REQ_SCR0, 22'h012340);
        REQ_CS = 4'b0010;
        c0 = cyc;
        bank_burst("single", 0, 22'h012340, 16'hBEEF, 16'hDEAD, 1'b0);
        chk("single_lat", 64'(cyc - c0), 64'(4));
        chk("single_ok", 64'(REQ_OK), 64'(4'b0010));
        chk("single_dout", 64'(dout_of(REQ_SCR0)), 64'(32'hDEADBEEF));

        // All four at once from rr_ptr=0, then 0 and 2 again
        do_reset();
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'((i + 1) * 22'h000100));
        REQ_CS = 4'b1111;
        for (int i = 0; i < NREQ; i++)
            bank_burst($sformatf("rr%0d", i), 0, AW'((i + 1) * 22'h000100),
                       16'h1000 + 16'(i), 16'hA000 + 16'(i), 1'b0);
        chk("rr_ok_all", 64'(REQ_OK), 64'(4'b1111));
        chk("rr_dout0", 64'(dout_of(0)), 64'(32'hA0001000));
        chk("rr_dout3", 64'(dout_of(3)), 64'(32'hA0031003));
        set_addr(REQ_OBJ, 22'h000111);
        set_addr(REQ_SCR1, 22'h000333);
        bank_burst("rr2_first", 0, 22'h000111, 16'h0B0B, 16'h0A0A, 1'b0);
        bank_burst("rr2_second", 0, 22'h000333, 16'h0D0D, 16'h0C0C, 1'b0);
        chk("rr2_ok", 64'(REQ_OK), 64'(4'b1111));
        chk("rr2_dout0", 64'(dout_of(0)), 64'(32'h0A0A0B0B));
        chk("rr2_dout2", 64'(dout_of(2)), 64'(32'h0C0C0D0D));

        // CS drop and re-assert with the same address on SCR2
        do_reset();
        set_addr(REQ_SCR2, 22'h3ABCDE);
        REQ_CS = 4'b1000;
        bank_burst("cache_fill", 0, 22'h3ABCDE, 16'h4321, 16'h8765, 1'b0);
        chk("cache_fill_ok", 64'(REQ_OK), 64'(4'b1000));
        REQ_CS = 4'b0000;
        repeat (5) @(negedge CLK);
        REQ_CS = 4'b1000;
        #1;
`ifdef GARE_GFX_ARB_CACHE_EN
        chk("cache_hit_ok", 64'(REQ_OK), 64'(4'b1000));
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("cache_no_rd", 64'(BA_RD), 64'(0));
        end
        chk("cache_hit_dout", 64'(dout_of(3)), 64'(32'h87654321));
`else
        chk("nocache_ok", 64'(REQ_OK), 64'(4'b0000));
        @(negedge CLK);
        bank_burst("nocache_refetch", 0, 22'h3ABCDE, 16'h9999, 16'h8888, 1'b0);
        chk("nocache_ok2", 64'(REQ_OK), 64'(4'b1000));
        chk("nocache_dout", 64'(dout_of(3)), 64'(32'h88889999));
`endif

        // Winner changes address during DATA
        do_reset();
        set_addr(REQ_OBJ, 22'h00D000);
        REQ_CS = 4'b0001;
        wait_rd("chg", 22'h00D000);
        BA_ACK = 1'b1;
        @(negedge CLK);
        BA_ACK = 1'b0; BA_DOK = 1'b1; DATA_READ = 16'h3333;
        set_addr(REQ_OBJ, 22'h00D002);
        @(negedge CLK);
        chk("chg_ba_addr", 64'(BA_ADDR), 64'(22'h00D000));
        BA_RDY = 1'b1; DATA_READ = 16'h4444;
        @(negedge CLK);
        BA_DOK = 1'b0; BA_RDY = 1'b0; DATA_READ = '0;
        chk("chg_ok_low", 64'(REQ_OK), 64'(0));
        chk("chg_stale_dout", 64'(dout_of(0)), 64'(32'h44443333));
        bank_burst("chg_refetch", 0, 22'h00D002, 16'h5555, 16'h6666, 1'b0);
        chk("chg_ok2", 64'(REQ_OK), 64'(4'b0001));
        chk("chg_dout2", 64'(dout_of(0)), 64'(32'h66665555));

        // Delayed ACK with a spurious beat during REQ
        do_reset();
        set_addr(REQ_SCR1, 22'h0E0E02);
        REQ_CS = 4'b0100;
        bank_burst("dly", 7, 22'h0E0E02, 16'hCAFE, 16'hF00D, 1'b1);
        chk("dly_ok", 64'(REQ_OK), 64'(4'b0100));
        chk("dly_dout", 64'(dout_of(2)), 64'(32'hF00DCAFE));

        // Reset pulsed during DATA with SCR1 still holding a valid result
        set_addr(REQ_SCR0, 22'h0F0F01);
        REQ_CS = 4'b0110;
        wait_rd("rstd", 22'h0F0F01);
        BA_ACK = 1'b1;
        @(negedge CLK);
        BA_ACK = 1'b0; BA_DOK = 1'b1; DATA_READ = 16'h1111;
        @(negedge CLK);
        BA_DOK = 1'b0; DATA_READ = '0;
        RESET = 1'b1;
        #1;
        chk("rstd_ba_rd", 64'(BA_RD), 64'(0));
        chk("rstd_ok", 64'(REQ_OK), 64'(0));
        chk("rstd_dout", 64'(REQ_DOUT), 64'(0));
        chk("rstd_ba_addr", 64'(BA_ADDR), 64'(0));
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0;
        bank_burst("rstd_reissue1", 0, 22'h0F0F01, 16'h7777, 16'h8888, 1'b0);
        bank_burst("rstd_reissue2", 0, 22'h0E0E02, 16'h2222, 16'h3333, 1'b0);
        chk("rstd_ok2", 64'(REQ_OK), 64'(4'b0110));
        chk("rstd_dout1", 64'(dout_of(1)), 64'(32'h88887777));
        chk("rstd_dout2", 64'(dout_of(2)), 64'(32'h33332222));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
